// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the mux_scan channel multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
  localparam logic FLAG_COM    = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width that stays at least one bit even for a single-value range.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell timer for auto-scan: counts 0..DWELL-1 while enabled and flags the wrap cycle.
module mux_dwell_cnt
  import mux_pkg::*;
#(
  parameter int DWELL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CNT_W = sel_width(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // A clear in the same cycle suppresses the wrap so a mode change wins.
  assign wrap = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan.sv
// N-channel registered mux with manual select and auto-scan; channel-change blanking
// is compiled in when MUX_SCAN_BLANK_EN is defined.
module mux_scan
  import mux_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 4,
  parameter int DWELL     = 1024,
  parameter int BLANK_CYC = 2,
  localparam int SEL_W    = sel_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] d,
  output logic [DATA_W:0]        q,
  output logic [SEL_W-1:0]       q_ch,
  output logic                   q_valid,
  output logic                   ch_strobe
);

`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam int BLANK_W = sel_width(BLANK_CYC + 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  logic [SEL_W-1:0]   idx;
  logic               mode_q;
  logic               fresh;
  logic [BLANK_W-1:0] bcnt;

  logic               sel_ok;
  logic               entry;
  logic               wrap;
  logic               dwell_en;
  logic               dwell_clr;
  logic [SEL_W-1:0]   idx_inc;
  logic [SEL_W-1:0]   ch_nx;
  logic               ch_ok;
  logic               changed;
  logic               flag_nx;
  logic [DATA_W-1:0]  data_nx;

  assign sel_ok  = (sel <= LAST_CH);
  assign idx_inc = (idx == LAST_CH) ? '0 : idx + SEL_W'(1);

  // The first enabled cycle after reset counts as scan entry so channel 0 gets a full dwell.
  assign entry     = (mode == MODE_SCAN) && (fresh || (mode_q != MODE_SCAN));
  assign dwell_en  = en && (mode == MODE_SCAN);
  assign dwell_clr = en && ((mode == MODE_MANUAL) || entry);

  mux_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dwell_en),
    .clr   (dwell_clr),
    .wrap  (wrap)
  );

  always_comb begin
    ch_nx = q_ch;
    ch_ok = 1'b1;
    if (mode == MODE_SCAN) begin
      if (entry)     ch_nx = (fresh || !sel_ok) ? '0 : sel;
      else if (wrap) ch_nx = idx_inc;
      else           ch_nx = idx;
    end else begin
      ch_ok = sel_ok;
      ch_nx = sel_ok ? sel : q_ch;
    end

    data_nx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_nx == SEL_W'(k)) data_nx = d[k*DATA_W +: DATA_W];
    end
    flag_nx = (ch_nx != '0) ? ~FLAG_COM : FLAG_COM;
    changed = (ch_nx != q_ch);
  end

  // Output register stage: q, q_ch, q_valid, ch_strobe and the blanking countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      mode_q    <= MODE_MANUAL;
      fresh     <= 1'b1;
      bcnt      <= '0;
      q         <= '0;
      q_ch      <= '0;
      q_valid   <= 1'b0;
      ch_strobe <= 1'b0;
    end else if (en) begin
      fresh     <= 1'b0;
      mode_q    <= mode;
      q_ch      <= ch_nx;
      ch_strobe <= changed;
      if (mode == MODE_SCAN) idx <= ch_nx;
      if (BLANK_EN && changed && (BLANK_CYC > 0)) begin
        q       <= '0;
        q_valid <= 1'b0;
        bcnt    <= BLANK_LOAD;
      end else if (bcnt != '0) begin
        q       <= '0;
        q_valid <= 1'b0;
        bcnt    <= bcnt - BLANK_W'(1);
      end else begin
        q       <= ch_ok ? {flag_nx, data_nx} : '0;
        q_valid <= ch_ok;
      end
    end else begin
      ch_strobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 4-channel and a 3-channel instance share stimulus and are checked
// each cycle against a channel/dwell-time model, plus hand-computed literal points.
module tb_mux_scan;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef MUX_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, mode;
  logic [1:0]  sel;
  logic [15:0] d;
  logic [4:0]  q4, q3;
  logic [1:0]  ch4, ch3;
  logic        v4, v3, s4, s3;

  mux_scan #(.N_CH(4), .DATA_W(4), .DWELL(DWELL), .BLANK_CYC(BLANK)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .d(d),
    .q(q4), .q_ch(ch4), .q_valid(v4), .ch_strobe(s4)
  );

  mux_scan #(.N_CH(3), .DATA_W(4), .DWELL(DWELL), .BLANK_CYC(BLANK)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .d(d[11:0]),
    .q(q3), .q_ch(ch3), .q_valid(v3), .ch_strobe(s3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  // Model state: channel shown, cycles still owed to it, whether the last enabled cycle scanned.
  typedef struct {
    int ch;
    bit valid;
    int qv;
    bit strobe;
    int left;
    bit scan;
    bit fresh;
    int blank;
  } mdl_t;

  mdl_t m4, m3;

  function automatic mdl_t mreset();
    mdl_t r;
    r.ch = 0; r.valid = 0; r.qv = 0; r.strobe = 0;
    r.left = 0; r.scan = 0; r.fresh = 1; r.blank = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, int n, bit en_i, bit mode_i, int sel_i, logic [15:0] dv);
    mdl_t r;
    int nc;
    bit legal;
    r = m;
    if (!en_i) begin
      r.strobe = 0;
      return r;
    end
    legal = 1;
    if (mode_i) begin
      if (m.fresh || !m.scan) begin
        nc = (m.fresh || sel_i >= n) ? 0 : sel_i;
        r.left = DWELL - 1;
      end else if (m.left == 0) begin
        nc = (m.ch + 1) % n;
        r.left = DWELL - 1;
      end else begin
        nc = m.ch;
        r.left = m.left - 1;
      end
    end else begin
      legal = (sel_i < n);
      nc = legal ? sel_i : m.ch;
    end
    r.strobe = (nc != m.ch);
    r.ch = nc;
    r.scan = mode_i;
    r.fresh = 0;
    if (r.strobe) r.blank = BLANK_ON ? BLANK : 0;
    if (r.blank > 0) begin
      r.qv = 0;
      r.valid = 0;
      r.blank = r.blank - 1;
    end else begin
      r.valid = legal;
      r.qv = legal ? (((nc != 0) ? 16 : 0) | int'((dv >> (4 * nc)) & 16'hF)) : 0;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m4 = mreset();
      m3 = mreset();
    end else begin
      m4 = step(m4, 4, en, mode, int'(sel), d);
      m3 = step(m3, 3, en, mode, int'(sel), d);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("q4", 32'(q4), 32'(m4.qv));
      chk("ch4", 32'(ch4), 32'(m4.ch));
      chk("v4", 32'(v4), 32'(m4.valid));
      chk("s4", 32'(s4), 32'(m4.strobe));
      chk("q3", 32'(q3), 32'(m3.qv));
      chk("ch3", 32'(ch3), 32'(m3.ch));
      chk("v3", 32'(v3), 32'(m3.valid));
      chk("s3", 32'(s3), 32'(m3.strobe));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] seq_ch [16];
  logic [1:0] seq3   [16];
  logic [4:0] seq_q  [16];
  logic       seq_v  [16];
  logic       seq_s  [16];

  initial begin
    int n;
    int nstb;
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0; d = 16'hDCBA;
    tick(2);
    run = 1'b1;
    chk("rst_q", 32'(q4), 32'h0);
    chk("rst_ch", 32'(ch4), 32'h0);
    chk("rst_v", 32'(v4), 32'h0);
    chk("rst_s", 32'(s4), 32'h0);

    // Manual select: channel 0, then channel 2.
    rst_n = 1'b1; mode = 1'b0; sel = 2'd0;
    tick(1);
    chk("man0_q", 32'(q4), 32'h0A);
    chk("man0_v", 32'(v4), 32'h1);
    sel = 2'd2;
    tick(1);
    chk("man2_ch", 32'(ch4), 32'h2);
    chk("man2_stb", 32'(s4), 32'h1);
    tick(1);
    chk("man2_stb_off", 32'(s4), 32'h0);
    tick(1);
    chk("man2_q", 32'(q4), 32'h1C);
    chk("man2_q3", 32'(q3), 32'h1C);

    // Illegal select on the 3-channel instance.
    sel = 2'd3;
    tick(1);
    chk("n3_q", 32'(q3), 32'h0);
    chk("n3_v", 32'(v3), 32'h0);
    chk("n3_ch_hold", 32'(ch3), 32'h2);
    chk("n3_stb", 32'(s3), 32'h0);
    tick(2);

    // Auto-scan from channel 0.
    mode = 1'b1; sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      seq_ch[i] = ch4; seq3[i] = ch3; seq_q[i] = q4; seq_v[i] = v4; seq_s[i] = s4;
    end
    chk("scan_ch0", 32'(seq_ch[0]), 32'h0);
    chk("scan_ch1", 32'(seq_ch[4]), 32'h1);
    chk("scan_ch2", 32'(seq_ch[8]), 32'h2);
    chk("scan_ch3", 32'(seq_ch[12]), 32'h3);
    chk("scan_ch3_end", 32'(seq_ch[15]), 32'h3);
    chk("scan_q0", 32'(seq_q[2]), 32'h0A);
    chk("scan_q1", 32'(seq_q[6]), 32'h1B);
    chk("scan_q2", 32'(seq_q[10]), 32'h1C);
    chk("scan_q3", 32'(seq_q[14]), 32'h1D);
    chk("n3_wrap", 32'(seq3[12]), 32'h0);
    nstb = 0;
    for (int i = 0; i < 16; i++) nstb += int'(seq_s[i]);
    chk("scan_strobes", 32'(nstb), 32'd4);
    chk("blank_v0", 32'(seq_v[0]), 32'(!BLANK_ON));
    chk("blank_v1", 32'(seq_v[1]), 32'(!BLANK_ON));
    chk("blank_v2", 32'(seq_v[2]), 32'h1);
    chk("blank_q0", 32'(seq_q[0]), BLANK_ON ? 32'h0 : 32'h0A);

    // Freeze three cycles mid-dwell on channel 0: it lasts 7 samples.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      en = !(i >= 2 && i < 5);
      tick(1);
      if (ch4 != 2'd0) break;
      n++;
    end
    en = 1'b1;
    chk("stretch", 32'(n), 32'd7);

    // On channel 1 with two dwell cycles elapsed, jump to manual channel 3, then rescan.
    tick(2);
    mode = 1'b0; sel = 2'd3;
    tick(1);
    chk("sw_ch", 32'(ch4), 32'h3);
    chk("sw_stb", 32'(s4), 32'h1);
    mode = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (ch4 != 2'd3) break;
      n++;
    end
    chk("sw_dwell", 32'(n), 32'd4);
    chk("sw_next", 32'(ch4), 32'h0);

    // Mixed patterns: mode toggling, enable gaps, wandering select and data, reset mid-dwell.
    for (int i = 0; i < 120; i++) begin
      en    = (i % 7 != 3);
      mode  = ((i / 13) % 2) == 0;
      sel   = 2'(i % 4);
      d     = 16'(32'hDCBA + i * 32'h1357);
      rst_n = !(i == 50 || i == 51);
      tick(1);
    end
    rst_n = 1'b1;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
